// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, result and external-ALU signal bundle for alu_arbiter
//
// Purpose: carries both requesters' request/operand signals, the completion
// and result outputs, and the registered drive to/combinational return from
// the shared external ALU.
// Modports:
//   slave  - the arbiter: samples req/op/a/b and alu_f, drives done/res/busy/alu_*
//   master - the environment: drives req/op/a/b and alu_f, observes the rest
interface alu_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0;
    logic             req1;
    logic [2:0]       op0;
    logic [2:0]       op1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] res;
    logic             res_zero;
    logic             busy;
    logic [2:0]       alu_s;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_f;

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1, alu_f,
        output done0, done1, res, res_zero, busy, alu_s, alu_a, alu_b
    );

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1, alu_f,
        input  done0, done1, res, res_zero, busy, alu_s, alu_a, alu_b
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one external ALU between two requesters
//
// Purpose: grants one of two requesters in IDLE, drives its operation to the
// external ALU for one EXEC cycle, captures the ALU result and pulses that
// requester's done for one cycle (DONE), then returns to IDLE.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - alu_arbiter_if.slave: req0/1, op0/1, a0/b0, a1/b1, alu_f in;
//           done0/1, res, res_zero, busy, alu_s, alu_a, alu_b out (all registered)
module alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;     // requester served most recently
    logic             grant_q, grant_d;   // requester owning the current transaction
    logic [2:0]       alu_s_q, alu_s_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             res_zero_q, res_zero_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             busy_q, busy_d;
    logic             pick1;

    // Requester 1 wins when it is alone, or when both ask and 0 was served last.
    assign pick1 = bus.req1 && (!bus.req0 || (last_q == 1'b0));

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_q;
        alu_s_d    = alu_s_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        res_d      = res_q;
        res_zero_d = res_zero_q;
        done0_d    = done0_q;
        done1_d    = done1_q;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant_d = pick1;
                    alu_s_d = pick1 ? bus.op1 : bus.op0;
                    alu_a_d = pick1 ? bus.a1  : bus.a0;
                    alu_b_d = pick1 ? bus.b1  : bus.b0;
                    state_d = EXEC;
                    busy_d  = 1'b1;
                end
            end
            EXEC: begin
                // alu_* are held; the ALU output has had a full cycle to settle.
                res_d      = bus.alu_f;
                res_zero_d = (bus.alu_f == '0);
                done0_d    = !grant_q;
                done1_d    = grant_q;
                last_d     = grant_q;
                state_d    = DONE;
            end
            DONE: begin
                done0_d = 1'b0;
                done1_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                done0_d = 1'b0;
                done1_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            grant_q    <= 1'b0;
            alu_s_q    <= 3'd0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            res_q      <= '0;
            res_zero_q <= 1'b1;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            alu_s_q    <= alu_s_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            res_q      <= res_d;
            res_zero_q <= res_zero_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.alu_s    = alu_s_q;
    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.res      = res_q;
    assign bus.res_zero = res_zero_q;
    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   checking;

    alu_arbiter_if #(.WIDTH(W)) bus ();

    alu_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU used by the bench.
    function automatic logic [W-1:0] alu_fn(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        case (s)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return a + b;
            3'd4:    return a - b;
            3'd5:    return ~a;
            3'd6:    return a;
            default: return {W{1'b1}};
        endcase
    endfunction

    assign bus.alu_f = alu_fn(bus.alu_s, bus.alu_a, bus.alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-schedule model: a grant at edge number g makes the result
    // and done appear at edge g+1, and the next grant can happen at g+3.
    int             cyc;
    int             free_at;
    int             done_at;
    int             m_who;
    int             m_last;
    logic [2:0]     m_s;
    logic [W-1:0]   m_a, m_b, m_res;
    logic           m_rz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_at = 0;
            done_at = -100;
            m_last  = 1;
            m_who   = 0;
            m_s     = 3'd0;
            m_a     = '0;
            m_b     = '0;
            m_res   = '0;
            m_rz    = 1'b1;
        end else begin
            cyc++;
            if (cyc == done_at) begin
                m_res  = alu_fn(m_s, m_a, m_b);
                m_rz   = (m_res == 0);
                m_last = m_who;
            end
            if (cyc >= free_at && (bus.req0 || bus.req1)) begin
                if (bus.req0 && bus.req1) m_who = 1 - m_last;
                else                      m_who = bus.req0 ? 0 : 1;
                m_s     = (m_who == 1) ? bus.op1 : bus.op0;
                m_a     = (m_who == 1) ? bus.a1  : bus.a0;
                m_b     = (m_who == 1) ? bus.b1  : bus.b0;
                done_at = cyc + 1;
                free_at = cyc + 3;
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (checking) begin
            logic exp_busy, exp_d0, exp_d1;
            exp_busy = rst_n && (cyc < free_at - 1);
            exp_d0   = rst_n && (cyc == done_at) && (m_who == 0);
            exp_d1   = rst_n && (cyc == done_at) && (m_who == 1);
            chk("cmp_alu_s",    32'(bus.alu_s),    32'(m_s));
            chk("cmp_alu_a",    32'(bus.alu_a),    32'(m_a));
            chk("cmp_alu_b",    32'(bus.alu_b),    32'(m_b));
            chk("cmp_res",      32'(bus.res),      32'(m_res));
            chk("cmp_res_zero", 32'(bus.res_zero), 32'(m_rz));
            chk("cmp_busy",     32'(bus.busy),     32'(exp_busy));
            chk("cmp_done0",    32'(bus.done0),    32'(exp_d0));
            chk("cmp_done1",    32'(bus.done1),    32'(exp_d1));
            chk("cmp_done_excl", 32'(bus.done0 & bus.done1), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        checking = 1'b0;
        cyc      = 0;
        rst_n    = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.op0  = 3'd0; bus.op1  = 3'd0;
        bus.a0   = '0;   bus.b0   = '0;
        bus.a1   = '0;   bus.b1   = '0;
        tick();
        tick();
        checking = 1'b1;
        chk("rst_alu_s",    32'(bus.alu_s),    32'd0);
        chk("rst_res",      32'(bus.res),      32'd0);
        chk("rst_res_zero", 32'(bus.res_zero), 32'd1);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("model_last",   32'(m_last),       32'd1);
        rst_n = 1'b1;
        tick();

        // Single request: 5 + 2.
        bus.req0 = 1'b1; bus.op0 = 3'd3; bus.a0 = 4'd5; bus.b0 = 4'd2;
        tick();
        chk("single_alu_s", 32'(bus.alu_s), 32'd3);
        chk("single_alu_a", 32'(bus.alu_a), 32'd5);
        chk("single_alu_b", 32'(bus.alu_b), 32'd2);
        chk("single_busy0", 32'(bus.busy),  32'd1);
        chk("single_nodone", 32'(bus.done0), 32'd0);
        tick();
        chk("single_done0", 32'(bus.done0), 32'd1);
        chk("single_res",   32'(bus.res),   32'd7);
        chk("single_busy1", 32'(bus.busy),  32'd1);
        chk("model_res7",   32'(m_res),     32'd7);
        bus.req0 = 1'b0;
        tick();
        chk("single_done_end", 32'(bus.done0), 32'd0);
        chk("single_busy_end", 32'(bus.busy),  32'd0);
        tick();

        // Simultaneous requests after reset: 0, 1, 0.
        reset_pulse();
        bus.req0 = 1'b1; bus.op0 = 3'd3; bus.a0 = 4'd1; bus.b0 = 4'd1;
        bus.req1 = 1'b1; bus.op1 = 3'd2; bus.a1 = 4'd6; bus.b1 = 4'd3;
        tick();
        chk("rr_first_s", 32'(bus.alu_s), 32'd3);
        tick();
        chk("rr_done0_a", 32'(bus.done0), 32'd1);
        chk("rr_res_a",   32'(bus.res),   32'd2);
        tick();
        tick();
        chk("rr_second_s", 32'(bus.alu_s), 32'd2);
        tick();
        chk("rr_done1",  32'(bus.done1), 32'd1);
        chk("rr_res_b",  32'(bus.res),   32'd5);
        tick();
        tick();
        chk("rr_third_s", 32'(bus.alu_s), 32'd3);
        tick();
        chk("rr_done0_b", 32'(bus.done0), 32'd1);
        drop_all();
        tick();
        tick();

        // Zero flag on requester 1.
        bus.req1 = 1'b1; bus.op1 = 3'd0; bus.a1 = 4'd5; bus.b1 = 4'd2;
        tick();
        tick();
        chk("zero_done1", 32'(bus.done1),    32'd1);
        chk("zero_done0", 32'(bus.done0),    32'd0);
        chk("zero_res",   32'(bus.res),      32'd0);
        chk("zero_flag",  32'(bus.res_zero), 32'd1);
        bus.req1 = 1'b0;
        tick();
        bus.req1 = 1'b1; bus.op1 = 3'd7;
        tick();
        tick();
        chk("ones_res",  32'(bus.res),      32'd15);
        chk("ones_flag", 32'(bus.res_zero), 32'd0);
        bus.req1 = 1'b0;
        tick();
        tick();

        // Request 1 arrives while requester 0 executes.
        bus.req0 = 1'b1; bus.op0 = 3'd1; bus.a0 = 4'd4; bus.b0 = 4'd1;
        tick();
        bus.req1 = 1'b1; bus.op1 = 3'd4; bus.a1 = 4'd9; bus.b1 = 4'd3;
        tick();
        chk("busy_hold_s", 32'(bus.alu_s), 32'd1);
        chk("busy_res",    32'(bus.res),   32'd5);
        bus.req0 = 1'b0;
        tick();
        chk("busy_hold_a", 32'(bus.alu_a), 32'd4);
        tick();
        chk("late_grant_s", 32'(bus.alu_s), 32'd4);
        chk("late_grant_a", 32'(bus.alu_a), 32'd9);
        tick();
        chk("late_res", 32'(bus.res), 32'd6);
        bus.req1 = 1'b0;
        tick();
        tick();

        // Reset during EXEC.
        bus.req0 = 1'b1; bus.op0 = 3'd6; bus.a0 = 4'hA; bus.b0 = 4'd0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_alu_s",  32'(bus.alu_s),    32'd0);
        chk("abort_busy",   32'(bus.busy),     32'd0);
        chk("abort_done0",  32'(bus.done0),    32'd0);
        chk("abort_res",    32'(bus.res),      32'd0);
        chk("abort_rzero",  32'(bus.res_zero), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("resume_s", 32'(bus.alu_s), 32'd6);
        chk("resume_a", 32'(bus.alu_a), 32'hA);
        tick();
        chk("resume_res", 32'(bus.res), 32'hA);

        // Back-to-back on requester 0: ~3, then 3 + 3.
        bus.op0 = 3'd5; bus.a0 = 4'd3; bus.b0 = 4'd0;
        tick();
        tick();
        chk("b2b_first_s", 32'(bus.alu_s), 32'd5);
        tick();
        chk("b2b_res1", 32'(bus.res), 32'hC);
        bus.op0 = 3'd3; bus.b0 = 4'd3;
        tick();
        chk("b2b_gap", 32'(bus.done0), 32'd0);
        tick();
        chk("b2b_second_s", 32'(bus.alu_s), 32'd3);
        tick();
        chk("b2b_res2",  32'(bus.res),   32'd6);
        chk("b2b_done0", 32'(bus.done0), 32'd1);
        bus.req0 = 1'b0;
        tick();
        tick();

        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
